// File: rtl/core_pc_ctrl.sv
// core_pc_ctrl: program counter owner and fetch/flush/hold controller.
//
// Takes hold and jump requests from the execute stage and turns them into:
//   - the fetch address (pc_out) and its request strobe,
//   - flush/hold controls for the IF/ID and ID/EX pipeline registers,
//   - a sticky trap when a jump targets a misaligned address.
//
// Fetch handshake (valid/ready): ifetch_req_out is the valid, ifetch_ready_in
// is the ready. A fetch is accepted on a rising edge where both are high.
// When valid is high and ready is low, pc_out is held stable and the pipeline
// is frozen. Valid is never raised in a cycle that also takes a jump, so a
// request is never withdrawn in favour of a different address.
//
// Priority in each cycle: rst > TRAP > jump > hold > increment.
// A jump that arrives while bus_hold_in is high is parked in a one-entry
// pending slot. The newest request overwrites the slot, and the slot is
// applied on the first cycle without a bus hold unless a fresh jump arrives
// in that same cycle.

module core_pc_ctrl #(
  parameter logic [31:0] RESET_ADDR    = 32'h0000_0000,
  parameter int          FETCH_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_flag_in,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  input  logic        bus_hold_in,
  input  logic        ifetch_ready_in,
  output logic [31:0] pc_out,
  output logic        ifetch_req_out,
  output logic        flush_out,
  output logic        hold_out,
  output logic        trap_out,
  output logic [31:0] trap_addr_out,
  output logic [1:0]  state_dbg
);

  // Length of the post-jump flush window, counted in accepted fetches.
  localparam logic [2:0] FLUSH_LEN = 3'(FETCH_LATENCY);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  state_t      state;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [2:0]  flush_cnt;

  logic        active;
  logic        in_flush;
  logic        take_jump;
  logic [31:0] jump_target;
  logic        jump_misaligned;
  logic        park_jump;
  logic        stall_hold;
  logic        fetch_req;
  logic        fetch_fire;
  logic [31:0] pc_next_seq;

  // Per-cycle decisions from the current state and requests.
  always_comb begin
    active          = (state == ST_RUN) || (state == ST_FLUSH);
    in_flush        = (state == ST_FLUSH);
    // A fresh jump takes precedence over the parked one.
    jump_target     = jump_flag_in ? jump_addr_in : pend_addr;
    jump_misaligned = (jump_target[1:0] != 2'b00);
    take_jump       = active && !bus_hold_in && (jump_flag_in || pend_valid);
    park_jump       = active && bus_hold_in && jump_flag_in;
    // A taken jump overrides hold_flag_in. bus_hold_in never coexists with
    // take_jump because a jump is parked while the bus is held.
    stall_hold      = active && !take_jump && (bus_hold_in || hold_flag_in);
    fetch_req       = active && !take_jump && !stall_hold;
    fetch_fire      = fetch_req && ifetch_ready_in;
    pc_next_seq     = pc_out + 32'd4;
  end

  // Pipeline controls decoded from the state and this cycle's decisions.
  always_comb begin
    ifetch_req_out = 1'b0;
    hold_out       = 1'b0;
    flush_out      = 1'b1;
    if (!rst) begin
      unique case (state)
        ST_BOOT: begin
          ifetch_req_out = 1'b0;
          hold_out       = 1'b0;
          flush_out      = 1'b1;
        end
        ST_TRAP: begin
          ifetch_req_out = 1'b0;
          hold_out       = 1'b1;
          flush_out      = 1'b1;
        end
        default: begin
          ifetch_req_out = fetch_req;
          // Freeze on an explicit hold or on a request the memory has not accepted.
          hold_out       = stall_hold || (fetch_req && !ifetch_ready_in);
          // Flush on every cycle of the window and on the jump cycle itself,
          // including a jump that ends in a trap.
          flush_out      = in_flush || take_jump;
        end
      endcase
    end
  end

  assign state_dbg = state;

  // State machine: program counter, pending jump, flush window and trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_BOOT;
      pc_out        <= RESET_ADDR;
      pend_valid    <= 1'b0;
      pend_addr     <= 32'h0000_0000;
      flush_cnt     <= 3'd0;
      trap_out      <= 1'b0;
      trap_addr_out <= 32'h0000_0000;
    end else begin
      unique case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end
        ST_RUN, ST_FLUSH: begin
          if (take_jump) begin
            pend_valid <= 1'b0;
            if (jump_misaligned) begin
              trap_out      <= 1'b1;
              trap_addr_out <= jump_target;
              state         <= ST_TRAP;
            end else begin
              pc_out    <= jump_target;
              flush_cnt <= FLUSH_LEN;
              state     <= ST_FLUSH;
            end
          end else if (park_jump) begin
            // The latest jump seen during a bus hold is the one that survives.
            pend_valid <= 1'b1;
            pend_addr  <= jump_addr_in;
          end else if (fetch_fire) begin
            pc_out <= pc_next_seq;
            if (in_flush) begin
              // The window shrinks only on accepted fetches, so stalls stretch it.
              flush_cnt <= flush_cnt - 3'd1;
              if (flush_cnt == 3'd1) begin
                state <= ST_RUN;
              end
            end
          end
        end
        ST_TRAP: begin
          // Sticky: only rst leaves this state.
          state <= ST_TRAP;
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_pc_ctrl.sv
// tb_core_pc_ctrl: randomized and directed stimulus for core_pc_ctrl.
// A behavioural model predicts all outputs for each cycle and queues them.
// A monitor on the falling edge pops the queued values and compares them
// against the DUT outputs.

module tb_core_pc_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int          FL         = 2;
  localparam int          W          = 68;

  // Clock and reset.
  logic        clk = 1'b0;
  logic        rst;
  logic        hold_flag_in;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        bus_hold_in;
  logic        ifetch_ready_in;
  logic [31:0] pc_out;
  logic        ifetch_req_out;
  logic        flush_out;
  logic        hold_out;
  logic        trap_out;
  logic [31:0] trap_addr_out;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  core_pc_ctrl #(
    .RESET_ADDR   (RESET_ADDR),
    .FETCH_LATENCY(FL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hold_flag_in   (hold_flag_in),
    .jump_flag_in   (jump_flag_in),
    .jump_addr_in   (jump_addr_in),
    .bus_hold_in    (bus_hold_in),
    .ifetch_ready_in(ifetch_ready_in),
    .pc_out         (pc_out),
    .ifetch_req_out (ifetch_req_out),
    .flush_out      (flush_out),
    .hold_out       (hold_out),
    .trap_out       (trap_out),
    .trap_addr_out  (trap_addr_out),
    .state_dbg      (state_dbg)
  );

  // Scoreboard: expected {pc, req, hold, flush, trap, trap_addr} for each cycle.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain facts about the controller.
  logic [31:0] m_pc       = RESET_ADDR;
  bit          m_booting  = 1'b1;
  bit          m_trapped  = 1'b0;
  logic [31:0] m_trap_a   = 32'h0;
  int          m_left     = 0;   // accepted fetches left in the flush window
  bit          m_pend     = 1'b0;
  logic [31:0] m_pend_a   = 32'h0;

  // Predict this cycle's outputs from the model and the inputs, push them,
  // then advance the model to the state it will hold after the edge.
  task automatic model_step();
    bit   req;
    bit   hold;
    bit   flush;
    logic [31:0] tgt;
    req = 0; hold = 0; flush = 1;
    if (rst) begin
      exp_q.push_back({m_pc, 1'b0, 1'b0, 1'b1, m_trapped, m_trap_a});
      m_pc = RESET_ADDR; m_booting = 1; m_trapped = 0; m_trap_a = 0;
      m_left = 0; m_pend = 0; m_pend_a = 0;
      return;
    end
    if (m_booting) begin
      exp_q.push_back({m_pc, 1'b0, 1'b0, 1'b1, m_trapped, m_trap_a});
      m_booting = 0;
      return;
    end
    if (m_trapped) begin
      exp_q.push_back({m_pc, 1'b0, 1'b1, 1'b1, m_trapped, m_trap_a});
      return;
    end
    if (bus_hold_in) begin
      hold = 1; flush = (m_left > 0);
      exp_q.push_back({m_pc, req, hold, flush, m_trapped, m_trap_a});
      if (jump_flag_in) begin
        m_pend = 1; m_pend_a = jump_addr_in;
      end
    end else if (jump_flag_in || m_pend) begin
      tgt = jump_flag_in ? jump_addr_in : m_pend_a;
      exp_q.push_back({m_pc, 1'b0, 1'b0, 1'b1, m_trapped, m_trap_a});
      m_pend = 0;
      if (tgt % 4 != 0) begin
        m_trapped = 1; m_trap_a = tgt;
      end else begin
        m_pc = tgt; m_left = FL;
      end
    end else if (hold_flag_in) begin
      hold = 1; flush = (m_left > 0);
      exp_q.push_back({m_pc, req, hold, flush, m_trapped, m_trap_a});
    end else begin
      req = 1; flush = (m_left > 0); hold = !ifetch_ready_in;
      exp_q.push_back({m_pc, req, hold, flush, m_trapped, m_trap_a});
      if (ifetch_ready_in) begin
        m_pc = m_pc + 32'd4;
        if (m_left > 0) m_left = m_left - 1;
      end
    end
  endtask

  // Driver: apply one cycle of inputs just after the rising edge.
  task automatic drive(input bit r, input bit hf, input bit jf, input logic [31:0] ja,
                       input bit bh, input bit rdy);
    @(posedge clk);
    #1;
    rst = r; hold_flag_in = hf; jump_flag_in = jf; jump_addr_in = ja;
    bus_hold_in = bh; ifetch_ready_in = rdy;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 0, 1);
  endtask

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endfunction

  // Monitor: compare the DUT outputs against the oldest prediction.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc_out",         pc_out,                  e[67:36]);
      check("ifetch_req_out", {31'h0, ifetch_req_out}, {31'h0, e[35]});
      check("hold_out",       {31'h0, hold_out},       {31'h0, e[34]});
      check("flush_out",      {31'h0, flush_out},      {31'h0, e[33]});
      check("trap_out",       {31'h0, trap_out},       {31'h0, e[32]});
      check("trap_addr_out",  trap_addr_out,           e[31:0]);
    end
  end

  // Stimulus: directed scenarios first, then a random phase.
  initial begin
    rst = 1; hold_flag_in = 0; jump_flag_in = 0; jump_addr_in = 0;
    bus_hold_in = 0; ifetch_ready_in = 1;
    @(posedge clk);
    drive(1, 0, 0, 32'h0, 0, 1);
    drive(1, 0, 0, 32'h0, 0, 1);
    // Boot cycle, then 0x0 and 0x4; the jump is issued while pc is 0x8.
    idle(3);
    drive(0, 0, 1, 32'h100, 0, 1);
    idle(4);
    // Memory stall for three cycles.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 0, 0);
    idle(2);
    // Bus hold for four cycles with two jumps; the later jump wins.
    drive(0, 0, 0, 32'h0,   1, 1);
    drive(0, 0, 1, 32'h200, 1, 1);
    drive(0, 0, 1, 32'h300, 1, 1);
    drive(0, 0, 0, 32'h0,   1, 1);
    idle(5);
    // A jump wins over a simultaneous hold, then reset lands mid-window.
    drive(0, 1, 1, 32'h40, 0, 1);
    drive(0, 0, 0, 32'h0,  0, 0);
    drive(1, 0, 0, 32'h0,  0, 1);
    idle(4);
    // A misaligned target traps; later requests are ignored until reset.
    drive(0, 0, 1, 32'h102, 0, 1);
    drive(0, 0, 1, 32'h500, 0, 1);
    drive(0, 1, 0, 32'h0,   1, 1);
    idle(2);
    drive(1, 0, 0, 32'h0, 0, 1);
    idle(3);
    // A misaligned jump parked during a bus hold traps once the hold drops.
    drive(0, 0, 1, 32'h203, 1, 1);
    drive(0, 0, 0, 32'h0,   0, 1);
    idle(2);
    drive(1, 0, 0, 32'h0, 0, 1);
    idle(2);
    // Random phase.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ja;
      ja = {$urandom_range(0, 32'hFFFF), 16'h0} | ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 9) == 0) ja[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0,
            ja,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
